// File: rtl/search_and_add_pkg.sv
// Shared types for the search_and_add key-counting front end.
//   KEY_W/VAL_W : record field widths
//   record_t    : {key, value} payload as pushed on din
//   state_t     : control FSM states
package search_and_add_pkg;

   localparam int unsigned KEY_W = 128;
   localparam int unsigned VAL_W = 32;
   localparam int unsigned REC_W = KEY_W + VAL_W;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] value;
   } record_t;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_READ,
      ST_MATCH,
      ST_EMIT
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read request (ignored while empty); dout updates on the edge of an accepted pop
//   full/empty : registered occupancy flags reflecting the count after this cycle's push/pop
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_next_c;
   logic             do_push_c;
   logic             do_pop_c;

   // Accepted operations and resulting occupancy
   always_comb begin
      do_push_c    = push && !full;
      do_pop_c     = pop && !empty;
      count_next_c = count + (AW+1)'(do_push_c) - (AW+1)'(do_pop_c);
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push_c)
         mem[wr_ptr] <= din;
   end

   // Pointers, count, flags and read register
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         dout   <= '0;
      end else begin
         if (do_push_c)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop_c) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next_c;
         full  <= (count_next_c == (AW+1)'(DEPTH));
         empty <= (count_next_c == '0);
      end
   end

endmodule

// File: rtl/search_and_add.sv
// Key-counting front end: buffers {key, value} records, maps each key to a dense
// slot through an associative table, and issues one accumulate per record.
//   clk, reset            : clock, synchronous active-high reset
//   ready                 : table initialised, block usable
//   kick                  : start draining the input FIFO (honoured in IDLE only)
//   busy                  : drain in progress
//   din, we, full         : record push interface
//   accum_addr/din/we     : accumulate command to the downstream memory
module search_and_add
   import search_and_add_pkg::*;
#(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic         clk,
   input  logic         reset,
   output logic         ready,
   input  logic         kick,
   output logic         busy,
   input  logic [159:0] din,
   input  logic         we,
   output logic         full,
   output logic [31:0]  accum_addr,
   output logic [63:0]  accum_din,
   output logic         accum_we
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   state_t           state;
   record_t          rec;
   logic             fifo_empty;
   logic             push_c;
   logic             pop_c;
   logic [KEY_W-1:0] keys [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [IDX_W:0]   alloc;
   logic [IDX_W:0]   clr_idx;
   logic [IDX_W-1:0] slot;
   logic [IDX_W-1:0] hit_idx_c;
   logic             hit_c;

   // ready is low throughout INIT, so pushes there are dropped
   assign push_c = we && ready;
   assign pop_c  = (state == ST_READ) && !fifo_empty;

   sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .din   (din),
      .pop   (pop_c),
      .dout  (rec),
      .full  (full),
      .empty (fifo_empty)
   );

   // Parallel key compare; keys are unique so at most one entry matches
   always_comb begin
      hit_c     = 1'b0;
      hit_idx_c = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (valid[i] && (keys[i] == rec.key)) begin
            hit_c     = 1'b1;
            hit_idx_c = IDX_W'(i);
         end
      end
   end

   // Control FSM, table update and accumulate command
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_INIT;
         ready      <= 1'b0;
         busy       <= 1'b0;
         accum_we   <= 1'b0;
         accum_addr <= '0;
         accum_din  <= '0;
         clr_idx    <= '0;
         alloc      <= '0;
         slot       <= '0;
      end else begin
         accum_we <= 1'b0;
         case (state)
            ST_INIT: begin
               alloc <= '0;
               if (clr_idx == (IDX_W+1)'(DEPTH)) begin
                  state <= ST_IDLE;
                  ready <= 1'b1;
               end else begin
                  valid[clr_idx[IDX_W-1:0]] <= 1'b0;
                  clr_idx <= clr_idx + (IDX_W+1)'(1);
               end
            end
            ST_IDLE: begin
               if (kick) begin
                  state <= ST_READ;
                  busy  <= 1'b1;
               end
            end
            ST_READ: begin
               if (fifo_empty) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= ST_MATCH;
               end
            end
            ST_MATCH: begin
               if (hit_c) begin
                  slot  <= hit_idx_c;
                  state <= ST_EMIT;
               end else if (alloc != (IDX_W+1)'(DEPTH)) begin
                  keys[alloc[IDX_W-1:0]]  <= rec.key;
                  valid[alloc[IDX_W-1:0]] <= 1'b1;
                  slot  <= alloc[IDX_W-1:0];
                  alloc <= alloc + (IDX_W+1)'(1);
                  state <= ST_EMIT;
               end else begin
                  // Table exhausted: record is dropped
                  state <= ST_READ;
               end
            end
            ST_EMIT: begin
               accum_addr <= 32'(slot);
               accum_din  <= {32'h0, rec.value};
               accum_we   <= 1'b1;
               state      <= ST_READ;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_search_and_add.sv
module tb_search_and_add;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         kick = 1'b0;
   logic         we = 1'b0;
   logic [159:0] din = '0;
   logic         ready;
   logic         busy;
   logic         full;
   logic [31:0]  accum_addr;
   logic [63:0]  accum_din;
   logic         accum_we;

   int vectors = 0;
   int miscompares = 0;
   int busy_cycles;

   logic [31:0] got_addr [$];
   logic [63:0] got_din  [$];
   logic [31:0] exp_addr [$];
   logic [63:0] exp_din  [$];

   localparam logic [127:0] K1 = 128'hDEADBEEF_ABADCAFE_FEFEFEFE_34343434;
   localparam logic [127:0] K2 = 128'h00C0FFEE_01234567_89ABCDEF_01234567;
   localparam logic [127:0] K3 = 128'hDEADBA11_ABADCAFE_FEFEFEFE_34343434;

   search_and_add #(.DEPTH(16), .FIFO_DEPTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .ready      (ready),
      .kick       (kick),
      .busy       (busy),
      .din        (din),
      .we         (we),
      .full       (full),
      .accum_addr (accum_addr),
      .accum_din  (accum_din),
      .accum_we   (accum_we)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] gen_key(input int i);
      gen_key = {32'hC0DE0000 | 32'(i), 96'h1111_2222_3333_4444_5555_6666};
   endfunction

   task automatic push_rec(input logic [127:0] key, input logic [31:0] val);
      din = {key, val};
      we  = 1'b1;
      tick();
      we  = 1'b0;
   endtask

   task automatic expect_accum(input logic [31:0] a, input logic [31:0] v);
      exp_addr.push_back(a);
      exp_din.push_back({32'h0, v});
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 100 && !ready; i++) tick();
      check("ready_wait", 64'(ready), 64'd1);
   endtask

   // Kick, collect accumulate strobes until busy drops, compare to expected list
   task automatic kick_and_drain(input string tag);
      logic done;
      got_addr.delete();
      got_din.delete();
      kick = 1'b1;
      tick();
      kick = 1'b0;
      check({tag, "_busy_rise"}, 64'(busy), 64'd1);
      busy_cycles = 0;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (accum_we) begin
            got_addr.push_back(accum_addr);
            got_din.push_back(accum_din);
         end
         if (busy) busy_cycles++;
         else done = 1'b1;
         if (!done) tick();
      end
      check({tag, "_busy_fall"}, 64'(done), 64'd1);
      check({tag, "_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
         check($sformatf("%s_din%0d", tag, i), got_din[i], exp_din[i]);
      end
      exp_addr.delete();
      exp_din.delete();
   endtask

   initial begin
      logic quiet;

      // Reset values and init timing
      repeat (10) tick();
      check("rst_ready", 64'(ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_full", 64'(full), 64'd0);
      check("rst_accum_we", 64'(accum_we), 64'd0);
      check("rst_accum_addr", 64'(accum_addr), 64'd0);
      check("rst_accum_din", accum_din, 64'd0);
      reset = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (busy || accum_we) quiet = 1'b0;
      end
      check("init_ready_low", 64'(ready), 64'd0);
      check("init_quiet", 64'(quiet), 64'd1);
      tick();
      check("init_ready_high", 64'(ready), 64'd1);

      // Two new keys
      push_rec(K1, 32'h5A5A5A5A);
      push_rec(K2, 32'h89ABCDEF);
      expect_accum(32'd0, 32'h5A5A5A5A);
      expect_accum(32'd1, 32'h89ABCDEF);
      kick_and_drain("two_keys");
      check("hold_we", 64'(accum_we), 64'd0);
      check("hold_addr", 64'(accum_addr), 64'd1);
      check("hold_din", accum_din, 64'h0000_0000_89AB_CDEF);

      // New key gets next slot
      push_rec(K3, 32'h5A5A5A5A);
      expect_accum(32'd2, 32'h5A5A5A5A);
      kick_and_drain("new_key");

      // Repeated key hits slot 0
      push_rec(K1, 32'h3);
      expect_accum(32'd0, 32'h3);
      kick_and_drain("hit_key");

      // Fresh table, overfill the FIFO
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      wait_ready();
      for (int i = 0; i < 18; i++) begin
         push_rec(gen_key(i), 32'h100 + 32'(i));
         if (i == 14) check("full_at_15", 64'(full), 64'd0);
         if (i == 15) check("full_at_16", 64'(full), 64'd1);
      end
      check("full_after_extra", 64'(full), 64'd1);
      for (int i = 0; i < 16; i++) expect_accum(32'(i), 32'h100 + 32'(i));
      kick_and_drain("fill");
      check("full_after_drain", 64'(full), 64'd0);

      // Table exhausted: new key dropped, existing key still hits
      push_rec(gen_key(40), 32'h1);
      push_rec(gen_key(3), 32'h7);
      expect_accum(32'd3, 32'h7);
      kick_and_drain("table_full");

      // Empty kick: single-cycle busy, no accumulate
      kick_and_drain("empty");
      check("empty_busy_len", 64'(busy_cycles), 64'd1);

      // Reset in the middle of a drain
      push_rec(gen_key(5), 32'h105);
      push_rec(gen_key(6), 32'h106);
      kick = 1'b1;
      tick();
      kick = 1'b0;
      tick();
      tick();
      tick();
      check("mid_accum_we", 64'(accum_we), 64'd1);
      check("mid_accum_addr", 64'(accum_addr), 64'd5);
      reset = 1'b1;
      tick();
      check("mid_rst_ready", 64'(ready), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_full", 64'(full), 64'd0);
      check("mid_rst_accum_we", 64'(accum_we), 64'd0);
      check("mid_rst_accum_addr", 64'(accum_addr), 64'd0);
      check("mid_rst_accum_din", accum_din, 64'd0);
      reset = 1'b0;
      wait_ready();
      push_rec(gen_key(6), 32'h206);
      push_rec(gen_key(9), 32'h209);
      expect_accum(32'd0, 32'h206);
      expect_accum(32'd1, 32'h209);
      kick_and_drain("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/search_and_add.md
# search_and_add

Key-counting front end for the wordcount pipeline. Buffers {key, value} records in an input FIFO. On `kick`, it drains the FIFO, resolves each 128-bit key to a dense slot index through an internal associative table, and issues one accumulate command (slot address plus increment) per record to the downstream accumulator memory.

## Interface
- `DEPTH`, 16: associative-table entries (power of two, 2..256); slot indices are 0..DEPTH-1.
- `FIFO_DEPTH`, 16: input FIFO entries (power of two).
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `ready` out 1: initialisation done, block usable.
- `kick` in 1: single-cycle start-of-drain request.
- `busy` out 1: drain in progress.
- `din` in 160: record. `din[159:32]` is the key; `din[31:0]` is the value (increment).
- `we` in 1: push `din` into the FIFO.
- `full` out 1: FIFO holds FIFO_DEPTH records.
- `accum_addr` out 32: slot index, zero-extended.
- `accum_din` out 64: `{32'h0, value}`.
- `accum_we` out 1: one-cycle accumulate strobe.

## Operation
- States: INIT, IDLE, READ, MATCH, EMIT.
- INIT (entered on reset):
  - Clears the table's valid bits one entry per cycle (DEPTH cycles).
  - Empties the FIFO and sets the allocation pointer to 0.
  - Then moves to IDLE with `ready`=1; `ready` stays 1 until the next reset.
- Push: `we`=1 with `ready`=1 and `full`=0 stores `din`. Pushes are accepted in any non-INIT state, including while busy. A push while full or during INIT is dropped silently.
- IDLE:
  - `kick`=1 moves to READ, regardless of FIFO contents.
  - `kick` in any other state is ignored.
- READ:
  - FIFO empty: go to IDLE.
  - Otherwise pop the head into a record register and go to MATCH.
- MATCH: compare the key in parallel against all valid entries.
  - Hit: slot = matching index.
  - Miss with alloc < DEPTH: write the key at slot = alloc, mark it valid, increment alloc.
  - Miss with the table full: drop the record, issue no accumulate, go back to READ.
- EMIT: drive `accum_addr`, `accum_din` and `accum_we`=1 for one cycle, then go to READ.
- The drain continues until the FIFO is found empty in READ, so records pushed mid-drain are included.
- A key never occupies two slots. Slots are assigned in first-seen order.

## Timing
- Reset values: `ready`=0, `busy`=0, `full`=0, `accum_we`=0, `accum_addr`=0, `accum_din`=0.
- All outputs are registered.
- `ready` rises DEPTH+1 cycles after the cycle in which `reset` is released.
- `busy` rises the cycle after an accepted `kick`. It is 1 in READ/MATCH/EMIT and falls when READ finds the FIFO empty.
- Per record: 3 cycles from pop to `accum_we` (READ, MATCH, EMIT). Throughput is one record per 3 cycles.
- `kick` with an empty FIFO gives a 1-cycle `busy` pulse and no `accum_we`.
- A simultaneous push and pop in the same cycle are both honoured; the count is unchanged.
- `full` reflects the count after the cycle's push/pop.
- Reset mid-drain: aborts immediately, loses FIFO and table contents, and re-enters INIT.
- `accum_addr` and `accum_din` hold their last values between strobes.

## Structure
- Package `search_and_add_pkg`:
  - constants `KEY_W`=128 and `VAL_W`=32;
  - `record_t` packed struct {key, value};
  - state enum.
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/full/empty, registered read). It holds the input buffer.
- The table, matcher and FSM live in the top.

## Test plan
- Reset held 10 cycles, then released: `ready` rises after DEPTH+1 cycles; `busy`/`accum_we` stay 0 throughout.
- Push {DEADBEEF_ABADCAFE_FEFEFEFE_34343434, 5A5A5A5A} and {00C0FFEE_01234567_89ABCDEF_01234567, 89ABCDEF}, then kick:
  - accum (0, 0x5A5A5A5A) then (1, 0x89ABCDEF);
  - `busy` drops after the FIFO empties.
- Continuing that run, push key DEADBA11_ABADCAFE_FEFEFEFE_34343434 with value 5A5A5A5A, then kick: new slot, accum (2, 0x5A5A5A5A).
- Push key DEADBEEF_ABADCAFE_FEFEFEFE_34343434 again with value 3, then kick: hit, accum (0, 0x3).
- Push FIFO_DEPTH+2 distinct keys without a kick:
  - `full`=1 after FIFO_DEPTH pushes and the extras are dropped;
  - with DEPTH=16 and an empty table, kick yields slots 0..15 in order.
- Kick with an empty FIFO gives a 1-cycle `busy` and no accum. Assert reset mid-drain: outputs return to reset values and the next drain restarts slot allocation at 0.
